// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; never below one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_mult_if.sv
// Operand/result bundle between the register inputs, the multiplier and the display logic.
interface seq_mult_if #(parameter int WIDTH = 8);
  import mult_pkg::*;

  // start is sampled only while the core is idle; a request seen in RUN or DONE
  // is dropped, not queued. done pulses for one cycle and P holds until the next
  // accepted start.
  logic                 start;
  logic                 sgn;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic                 X;
  logic [2*WIDTH-1:0]   P;
  state_t               state;

  modport master (output start, sgn, A, B, input busy, done, X, P, state);
  modport slave  (input start, sgn, A, B, output busy, done, X, P, state);

endinterface

// File: rtl/seq_mult_addsub.sv
// Ripple add/subtract with a sign (signed) or carry (unsigned) extension bit.
module addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sgn,
  output logic [WIDTH-1:0] s,
  output logic             e
);

  logic [WIDTH:0] xe;
  logic [WIDTH:0] ye;
  logic [WIDTH:0] r;
  logic [WIDTH:0] c;

  // Extending to WIDTH+1 bits keeps the overflow of the WIDTH-bit sum in e.
  assign xe   = {sgn & x[WIDTH-1], x};
  assign ye   = {sgn & y[WIDTH-1], y} ^ {(WIDTH+1){sub}};
  assign c[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign r[i] = xe[i] ^ ye[i] ^ c[i];
    if (i < WIDTH) begin : g_carry
      assign c[i+1] = (xe[i] & ye[i]) | (c[i] & (xe[i] ^ ye[i]));
    end
  end

  assign s = r[WIDTH-1:0];
  assign e = r[WIDTH];

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, signed or unsigned.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic        Clk,
  input  logic        Reset_n,
  seq_mult_if.slave   bus
);

  state_t             state_q;
  state_t             state_n;
  logic [CNT_W-1:0]   count;
  logic               x_q;
  logic               mode;
  logic [WIDTH-1:0]   ah;
  logic [WIDTH-1:0]   bl;
  logic [WIDTH-1:0]   m;
  logic               last;
  logic [WIDTH-1:0]   sum;
  logic               ext;
  logic [WIDTH-1:0]   s_sel;
  logic               e_sel;

  assign last = (count == CNT_W'(WIDTH - 1));

  // The final signed step subtracts: the multiplier MSB carries weight -2^(WIDTH-1).
  addsub_n #(.WIDTH(WIDTH)) u_addsub (
    .x   (ah),
    .y   (m),
    .sub (mode & last),
    .sgn (mode),
    .s   (sum),
    .e   (ext)
  );

  always_comb begin
    s_sel = sum;
    e_sel = ext;
    if (!bl[0]) begin
      s_sel = ah;
      e_sel = mode ? x_q : 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
      x_q   <= 1'b0;
      mode  <= 1'b0;
      ah    <= '0;
      bl    <= '0;
      m     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            m     <= bus.A;
            bl    <= bus.B;
            ah    <= '0;
            x_q   <= 1'b0;
            mode  <= bus.sgn;
            count <= '0;
          end
        end
        RUN: begin
          // Arithmetic right shift of {e, s, BL}; e also refills the AH MSB.
          {x_q, ah, bl} <= {e_sel, e_sel, s_sel, bl[WIDTH-1:1]};
          count         <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.X     = x_q;
  assign bus.P     = {ah, bl};
  assign bus.state = state_q;

endmodule
